// File: rtl/scarv_cop_aes_mc_if.sv
// scarv_cop_aes_mc_if: instruction handshake, operand and CPR writeback bundle for the AES unit
// master: issuing stage (drives aes_ivalid, operands, decode fields)
// slave:  AES unit (drives aes_idone and the CPR writeback byte enables/data)
interface scarv_cop_aes_mc_if;
    logic        aes_ivalid;
    logic        aes_idone;
    logic [31:0] aes_rs1;
    logic [31:0] aes_rs2;
    logic [31:0] aes_rs3;
    logic [31:0] id_imm;
    logic [2:0]  id_pw;
    logic [3:0]  id_class;
    logic [4:0]  id_subclass;
    logic [3:0]  aes_cpr_rd_ben;
    logic [31:0] aes_cpr_rd_wdata;
    modport master (
        output aes_ivalid, aes_rs1, aes_rs2, aes_rs3, id_imm, id_pw, id_class, id_subclass,
        input  aes_idone, aes_cpr_rd_ben, aes_cpr_rd_wdata
    );
    modport slave (
        input  aes_ivalid, aes_rs1, aes_rs2, aes_rs3, id_imm, id_pw, id_class, id_subclass,
        output aes_idone, aes_cpr_rd_ben, aes_cpr_rd_wdata
    );
endinterface

// File: rtl/scarv_cop_aes_mc.sv
// scarv_cop_aes_mc: multi-cycle AES SubBytes/MixColumn unit operating on one 32-bit column
// g_clk   : clock
// g_reset : asynchronous active-high reset
// bus     : slave side of the AES instruction bundle; rs1 carries the column
//           (byte i = row i), id_subclass selects SUB_ENC/SUB_DEC/MIX_ENC/MIX_DEC,
//           idone pulses for one cycle with the CPR writeback ben/wdata
module scarv_cop_aes_mc #(
    parameter int LANES = 1
) (
    input logic               g_clk,
    input logic               g_reset,
    scarv_cop_aes_mc_if.slave bus
);
    localparam int SUB_CYCLES = 4 / LANES;
    if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
        $error("LANES must be 1, 2 or 4");
    end
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t      state_q;
    logic [1:0]  cnt_q;
    logic [4:0]  op_q;
    logic [31:0] res_q;
    logic        idone_q;
    logic [3:0]  ben_q;
    logic [31:0] wdata_q;
    logic [31:0] sub_d;
    logic [31:0] mix_d;
    logic        sub_op;
    logic        mix_op;
    logic        sub_last;
    logic        unused_ok;
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction
    function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
        return (a << n) | (a >> (8 - n));
    endfunction
    // a^-1 = a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0 as the S-box needs
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] p;
        sq = gmul(a, a);
        p  = sq;
        for (int i = 0; i < 6; i++) begin
            sq = gmul(sq, sq);
            p  = gmul(p, sq);
        end
        return p;
    endfunction
    // One inverter shared by both directions: forward applies the affine map after
    // inversion, inverse applies the inverse affine map before it.
    function automatic logic [7:0] sbox(input logic [7:0] a, input logic enc);
        logic [7:0] v;
        v = ginv(enc ? a : rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
        return enc ? v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63 : v;
    endfunction
    function automatic logic [31:0] mix(input logic [31:0] c, input logic inv);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = gmul(c[8*i +: 8], inv ? 8'h0e : 8'h02)
                        ^ gmul(c[8*((i+1)%4) +: 8], inv ? 8'h0b : 8'h03)
                        ^ gmul(c[8*((i+2)%4) +: 8], inv ? 8'h0d : 8'h01)
                        ^ gmul(c[8*((i+3)%4) +: 8], inv ? 8'h09 : 8'h01);
        return r;
    endfunction
    assign sub_op   = op_q[4:1] == 4'd0;
    assign mix_op   = op_q[4:1] == 4'd1;
    assign sub_last = cnt_q == 2'((SUB_CYCLES - 1) * LANES);
    assign mix_d    = mix(res_q, op_q[0]);
    always_comb begin
        sub_d = res_q;
        for (int l = 0; l < LANES; l++)
            sub_d[{cnt_q + 2'(l), 3'b000} +: 8] = sbox(res_q[{cnt_q + 2'(l), 3'b000} +: 8], !op_q[0]);
    end
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            res_q   <= '0;
            idone_q <= 1'b0;
            ben_q   <= '0;
            wdata_q <= '0;
        end else begin
            idone_q <= 1'b0;
            ben_q   <= '0;
            wdata_q <= '0;
            case (state_q)
                IDLE: if (bus.aes_ivalid) begin
                    res_q   <= bus.aes_rs1;
                    op_q    <= bus.id_subclass;
                    cnt_q   <= '0;
                    state_q <= BUSY;
                end
                BUSY: if (!bus.aes_ivalid) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end else if (sub_op) begin
                    res_q <= sub_d;
                    cnt_q <= cnt_q + 2'(LANES);
                    if (sub_last) begin
                        state_q <= DONE;
                        idone_q <= 1'b1;
                        ben_q   <= 4'hf;
                        wdata_q <= sub_d;
                    end
                end else begin
                    state_q <= DONE;
                    idone_q <= 1'b1;
                    ben_q   <= mix_op ? 4'hf : 4'h0;
                    wdata_q <= mix_op ? mix_d : 32'h0;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end
    assign bus.aes_idone        = idone_q;
    assign bus.aes_cpr_rd_ben   = ben_q;
    assign bus.aes_cpr_rd_wdata = wdata_q;
    assign unused_ok = ^{bus.aes_rs2, bus.aes_rs3, bus.id_imm, bus.id_pw, bus.id_class};
endmodule

// File: tb/tb_scarv_cop_aes_mc.sv
// tb_scarv_cop_aes_mc: scoreboard bench for the AES unit at LANES 1, 2 and 4
module tb_scarv_cop_aes_mc;
    typedef struct {
        int          k;
        logic        chk;
        logic [3:0]  ben;
        logic [31:0] wdata;
        int          cyc;
    } exp_t;
    exp_t        q[$];
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  iv  = '0;
    logic [31:0] rs1 = '0;
    logic [4:0]  sub = '0;
    logic [2:0]  dn;
    logic [3:0]  ben [3];
    logic [31:0] wd  [3];
    int cyc = 0, vecs = 0, errs = 0, n_done = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    for (genvar g = 0; g < 3; g++) begin : g_dut
        scarv_cop_aes_mc_if bus();
        assign bus.aes_ivalid  = iv[g];
        assign bus.aes_rs1     = rs1;
        assign bus.aes_rs2     = 32'h0;
        assign bus.aes_rs3     = 32'h0;
        assign bus.id_imm      = 32'h0;
        assign bus.id_pw       = 3'h0;
        assign bus.id_class    = 4'h0;
        assign bus.id_subclass = sub;
        assign dn[g]  = bus.aes_idone;
        assign ben[g] = bus.aes_cpr_rd_ben;
        assign wd[g]  = bus.aes_cpr_rd_wdata;
        scarv_cop_aes_mc #(.LANES(1 << g)) u_dut (
            .g_clk   (clk),
            .g_reset (rst),
            .bus     (bus)
        );
    end
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (dn[k]) begin
                n_done++;
                if (q.size() == 0 || q[0].k != k) begin
                    errs++;
                    $display("FAIL unexpected_idone dut%0d cyc=%0d wdata=%h", k, cyc, wd[k]);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check($sformatf("latency dut%0d", k), cyc, e.cyc);
                    check($sformatf("ben dut%0d", k), {28'h0, ben[k]}, {28'h0, e.ben});
                    if (e.chk) check($sformatf("wdata dut%0d", k), wd[k], e.wdata);
                end
            end else if (ben[k] != 4'h0 || wd[k] != 32'h0) begin
                errs++;
                $display("FAIL idle_outputs dut%0d cyc=%0d ben=%h wdata=%h", k, cyc, ben[k], wd[k]);
            end
        end
    end
    task automatic issue(input int k, input logic [4:0] s, input logic [31:0] a, input logic chk,
                         input logic [3:0] eb, input logic [31:0] ew, output logic [31:0] got);
        exp_t e;
        bit   seen = 1'b0;
        int   lat  = (s < 5'd2) ? (4 >> k) + 1 : 2;
        @(negedge clk);
        rs1 = a;
        sub = s;
        iv[k] = 1'b1;
        e.k = k; e.chk = chk; e.ben = eb; e.wdata = ew; e.cyc = cyc + lat;
        q.push_back(e);
        got = 'x;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (dn[k]) begin
                seen = 1'b1;
                got = wd[k];
            end else begin
                rs1 = $urandom;
                sub = 5'($urandom);
            end
        end
        iv[k] = 1'b0;
        if (!seen) begin
            vecs++;
            errs++;
            $display("FAIL timeout dut%0d op=%0d rs1=%h", k, s, a);
            q.delete();
        end
    endtask
    task automatic abort_busy(input int k, input logic [4:0] s, input logic [31:0] a);
        int d0;
        @(negedge clk);
        rs1 = a;
        sub = s;
        iv[k] = 1'b1;
        d0 = n_done;
        repeat (2) @(negedge clk);
        iv[k] = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_no_idone", n_done - d0, 0);
    endtask
    initial begin
        logic [31:0] got;
        logic [31:0] a;
        int d0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_idone dut%0d", k), {31'h0, dn[k]}, 0);
            check($sformatf("rst_ben dut%0d", k), {28'h0, ben[k]}, 0);
            check($sformatf("rst_wdata dut%0d", k), wd[k], 0);
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) issue(k, 5'd0, 32'h00530001, 1, 4'hf, 32'h63ED637C, got);
        issue(0, 5'd0, 32'hFF802010, 1, 4'hf, 32'h16CDB7CA, got);
        issue(0, 5'd1, 32'h63ED637C, 1, 4'hf, 32'h00530001, got);
        issue(1, 5'd1, 32'h16CDB7CA, 1, 4'hf, 32'hFF802010, got);
        issue(0, 5'd2, 32'h455313DB, 1, 4'hf, 32'hBCA14D8E, got);
        issue(0, 5'd3, 32'hBCA14D8E, 1, 4'hf, 32'h455313DB, got);
        issue(0, 5'd2, 32'h01010101, 1, 4'hf, 32'h01010101, got);
        issue(0, 5'd2, 32'h5C220AF2, 1, 4'hf, 32'h9D58DC9F, got);
        issue(0, 5'd3, 32'h9D58DC9F, 1, 4'hf, 32'h5C220AF2, got);
        issue(2, 5'd2, 32'hD5D4D4D4, 1, 4'hf, 32'hD6D7D5D5, got);
        issue(0, 5'd7, 32'hFFFFFFFF, 1, 4'h0, 32'h0, got);
        issue(0, 5'd0, 32'h00000000, 1, 4'hf, 32'h63636363, got);
        issue(1, 5'd31, 32'h12345678, 1, 4'h0, 32'h0, got);
        abort_busy(0, 5'd0, 32'h00530001);
        issue(0, 5'd0, 32'h00530001, 1, 4'hf, 32'h63ED637C, got);
        @(negedge clk);
        rs1 = 32'h00530001;
        sub = 5'd0;
        iv[0] = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1 check("busy_rst_idone", {31'h0, dn[0]}, 0);
        iv[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        d0 = n_done;
        repeat (10) @(negedge clk);
        check("busy_rst_no_idone", n_done - d0, 0);
        issue(0, 5'd1, 32'h63ED637C, 1, 4'hf, 32'h00530001, got);
        issue(1, 5'd0, 32'hFF802010, 1, 4'hf, 32'h16CDB7CA, got);
        #1 rst = 1'b1;
        #1 check("done_rst_idone", {31'h0, dn[1]}, 0);
        check("done_rst_ben", {28'h0, ben[1]}, 0);
        check("done_rst_wdata", wd[1], 0);
        @(negedge clk);
        rst = 1'b0;
        for (int b = 0; b < 64; b++) begin
            a = {8'(4*b+3), 8'(4*b+2), 8'(4*b+1), 8'(4*b)};
            issue(2, 5'd0, a, 0, 4'hf, 32'h0, got);
            issue(2, 5'd1, got, 1, 4'hf, a, got);
        end
        repeat (5) @(negedge clk);
        check("scoreboard_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
